cgmii_rx_decoder: RTL and testbench



---
 rtl/cgmii_pkg.sv | 19 +
 rtl/cgmii_term_find.sv | 25 ++
 rtl/cgmii_rx_decoder.sv | 179 +++++++++++++++++
 tb/tb_cgmii_rx_decoder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cgmii_pkg.sv
// rtl/cgmii_pkg.sv - CGMII receive character constants, lane geometry and decoder state type
package cgmii_pkg;

    localparam int LANES  = 64;
    localparam int WORD_W = 512;

    localparam logic [7:0]  IDLE_CHAR  = 8'h07;
    localparam logic [7:0]  START_CHAR = 8'hFB;
    localparam logic [7:0]  TERM_CHAR  = 8'hFD;
    localparam logic [7:0]  ERROR_CHAR = 8'hFE;
    localparam logic [55:0] PREAMBLE   = 56'hD5555555555555;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        FLUSH = 2'd2
    } rx_state_t;

endpackage

// File: rtl/cgmii_term_find.sv
// rtl/cgmii_term_find.sv - lowest control lane finder with terminate-character check
module cgmii_term_find
    import cgmii_pkg::*;
(
    input  logic [WORD_W-1:0] rx_data,
    input  logic [LANES-1:0]  rx_ctrl,
    output logic [5:0]        t,
    output logic              found,
    output logic              is_term
);

    // Scan from the top lane down so the lowest set control bit wins.
    always_comb begin
        t = 6'd0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (rx_ctrl[i]) begin
                t = 6'(i);
            end
        end
    end

    assign found   = |rx_ctrl;
    assign is_term = found && (rx_data[{t, 3'b000} +: 8] == TERM_CHAR);

endmodule

// File: rtl/cgmii_rx_decoder.sv
// rtl/cgmii_rx_decoder.sv - CGMII 64-lane receive decoder to 64-byte beats; CGMII_RX_STATS_EN adds counters
module cgmii_rx_decoder
    import cgmii_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [511:0] rx_data,
    input  logic [63:0]  rx_ctrl,
    output logic [511:0] out_data,
    output logic         out_valid,
    output logic         out_sof,
    output logic         out_eof,
    output logic [5:0]   out_empty,
    output logic         out_err
`ifdef CGMII_RX_STATS_EN
    ,
    output logic [31:0]  stat_pkts,
    output logic [31:0]  stat_errs,
    output logic [31:0]  stat_runts
`endif
);

    rx_state_t      state, state_n;
    logic [447:0]   hold, hold_n;
    logic           pend_sof, pend_sof_n;
    logic [5:0]     flush_empty, flush_empty_n;
    logic           flush_err, flush_err_n;

    logic [511:0]   data_n;
    logic           valid_n, sof_n, eof_n, err_n;
    logic [5:0]     empty_n;
    logic           runt_evt;
    logic           idle_eval;

    logic [5:0]     t;
    logic           found, is_term;
    logic           start_ok, hi_ctrl, start_take, runt_hit;
    logic [511:0]   composed;
    logic [6:0]     flush_calc;

    cgmii_term_find u_term_find (
        .rx_data (rx_data),
        .rx_ctrl (rx_ctrl),
        .t       (t),
        .found   (found),
        .is_term (is_term)
    );

    // A Start beat carries the start char and preamble/SFD in lanes 0..7; any
    // control char higher up means the whole packet fits inside it (a runt).
    assign start_ok   = (rx_ctrl[7:0] == 8'h01) && (rx_data[7:0] == START_CHAR)
                        && (rx_data[63:8] == PREAMBLE);
    assign hi_ctrl    = |rx_ctrl[63:8];
    assign start_take = start_ok && !hi_ctrl;
    assign runt_hit   = start_ok && hi_ctrl;

    // Payload is shifted down by the 8 header bytes: held upper 56 bytes of the
    // previous beat followed by the low 8 bytes of this one.
    assign composed   = {rx_data[63:0], hold};
    assign flush_calc = 7'd72 - {1'b0, t};

    // Next-state and next-output decode.
    always_comb begin
        state_n       = state;
        hold_n        = hold;
        pend_sof_n    = pend_sof;
        flush_empty_n = flush_empty;
        flush_err_n   = flush_err;
        data_n        = out_data;
        valid_n       = 1'b0;
        sof_n         = 1'b0;
        eof_n         = 1'b0;
        empty_n       = 6'd0;
        err_n         = 1'b0;
        runt_evt      = 1'b0;
        idle_eval     = 1'b0;

        case (state)
            IDLE: begin
                idle_eval = 1'b1;
            end
            DATA: begin
                data_n     = composed;
                valid_n    = 1'b1;
                sof_n      = pend_sof;
                pend_sof_n = 1'b0;
                if (!found) begin
                    hold_n = rx_data[511:64];
                end else if (t <= 6'd8) begin
                    eof_n     = 1'b1;
                    empty_n   = 6'd8 - t;
                    err_n     = !is_term;
                    state_n   = IDLE;
                    idle_eval = 1'b1;
                end else begin
                    hold_n        = rx_data[511:64];
                    flush_empty_n = flush_calc[5:0];
                    flush_err_n   = !is_term;
                    state_n       = FLUSH;
                end
            end
            FLUSH: begin
                data_n    = composed;
                valid_n   = 1'b1;
                eof_n     = 1'b1;
                empty_n   = flush_empty;
                err_n     = flush_err;
                state_n   = IDLE;
                idle_eval = 1'b1;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Whenever the decoder is (or has just become) idle, the same beat may
        // open a new packet, which is what allows back-to-back frames.
        if (idle_eval) begin
            if (start_take) begin
                hold_n     = rx_data[511:64];
                pend_sof_n = 1'b1;
                state_n    = DATA;
            end else if (runt_hit) begin
                runt_evt = 1'b1;
            end
        end
    end

    // State, hold buffer and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            hold        <= '0;
            pend_sof    <= 1'b0;
            flush_empty <= 6'd0;
            flush_err   <= 1'b0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_sof     <= 1'b0;
            out_eof     <= 1'b0;
            out_empty   <= 6'd0;
            out_err     <= 1'b0;
        end else begin
            state       <= state_n;
            hold        <= hold_n;
            pend_sof    <= pend_sof_n;
            flush_empty <= flush_empty_n;
            flush_err   <= flush_err_n;
            out_data    <= data_n;
            out_valid   <= valid_n;
            out_sof     <= sof_n;
            out_eof     <= eof_n;
            out_empty   <= empty_n;
            out_err     <= err_n;
        end
    end

`ifdef CGMII_RX_STATS_EN
    // Saturating packet, error and runt counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_pkts  <= '0;
            stat_errs  <= '0;
            stat_runts <= '0;
        end else begin
            if (eof_n && !(&stat_pkts)) begin
                stat_pkts <= stat_pkts + 32'd1;
            end
            if (eof_n && err_n && !(&stat_errs)) begin
                stat_errs <= stat_errs + 32'd1;
            end
            if (runt_evt && !(&stat_runts)) begin
                stat_runts <= stat_runts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cgmii_rx_decoder.sv
// tb/tb_cgmii_rx_decoder.sv - directed self-checking bench for cgmii_rx_decoder
module tb_cgmii_rx_decoder;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [511:0] rx_data = '0;
    logic [63:0]  rx_ctrl = '0;
    logic [511:0] out_data;
    logic         out_valid, out_sof, out_eof, out_err;
    logic [5:0]   out_empty;
`ifdef CGMII_RX_STATS_EN
    logic [31:0]  stat_pkts, stat_errs, stat_runts;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [511:0] IDLE_BEAT = {64{8'h07}};
    localparam logic [63:0]  ALL_CTRL  = {64{1'b1}};

    cgmii_rx_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_ctrl   (rx_ctrl),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_sof   (out_sof),
        .out_eof   (out_eof),
        .out_empty (out_empty),
        .out_err   (out_err)
`ifdef CGMII_RX_STATS_EN
        ,
        .stat_pkts (stat_pkts),
        .stat_errs (stat_errs),
        .stat_runts(stat_runts)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [511:0] mk(input logic [7:0] seed);
        logic [511:0] r;
        for (int i = 0; i < 64; i++) r[8*i +: 8] = seed + 8'(i);
        return r;
    endfunction

    function automatic logic [511:0] mk_start(input logic [7:0] seed);
        logic [511:0] r;
        r = mk(seed);
        r[63:0] = {56'hD5555555555555, 8'hFB};
        return r;
    endfunction

    function automatic logic [511:0] with_byte(input logic [511:0] d, input int pos, input logic [7:0] b);
        logic [511:0] r;
        r = d;
        r[8*pos +: 8] = b;
        return r;
    endfunction

    function automatic logic [63:0] ctrl_from(input int pos);
        logic [63:0] r;
        r = ALL_CTRL << pos;
        return r;
    endfunction

    // Present one beat, then sample the registered result just after the edge.
    task automatic cyc(input logic [511:0] d, input logic [63:0] c);
        @(negedge clk);
        rx_data = d;
        rx_ctrl = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_beat(input string nm, input logic v, input logic s, input logic e,
                            input logic [5:0] emp, input logic er);
        n_cmp++;
        if ({out_valid, out_sof, out_eof, out_empty, out_err} !== {v, s, e, emp, er}) begin
            n_bad++;
            $display("FAIL %s: got v=%0b sof=%0b eof=%0b empty=%0d err=%0b, want v=%0b sof=%0b eof=%0b empty=%0d err=%0b",
                     nm, out_valid, out_sof, out_eof, out_empty, out_err, v, s, e, emp, er);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cyc(IDLE_BEAT, ALL_CTRL);
        cyc(IDLE_BEAT, ALL_CTRL);
        n_cmp++;
        if ({out_data, out_valid, out_sof, out_eof, out_empty, out_err} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got valid=%0b eof=%0b data_nonzero=%0b, want all zero",
                     out_valid, out_eof, |out_data);
        end
        rst = 1'b0;
        cyc(IDLE_BEAT, ALL_CTRL);
        chk_beat("reset_idle", 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    endtask

    task automatic test_pkt128;
        logic [511:0] s, d, t;
        s = mk_start(8'h10);
        d = mk(8'h40);
        t = with_byte(mk(8'h80), 8, 8'hFD);
        cyc(s, 64'h1);
        chk_beat("p128_start", 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
        cyc(d, 64'h0);
        chk_beat("p128_beat1", 1'b1, 1'b1, 1'b0, 6'd0, 1'b0);
        n_cmp++;
        if (out_data !== {d[63:0], s[511:64]}) begin
            n_bad++;
            $display("FAIL p128_data1: got %h want %h", out_data, {d[63:0], s[511:64]});
        end
        cyc(t, 64'hffff_ffff_ffff_ff00);
        chk_beat("p128_beat2", 1'b1, 1'b0, 1'b1, 6'd0, 1'b0);
        n_cmp++;
        if (out_data !== {t[63:0], d[511:64]}) begin
            n_bad++;
            $display("FAIL p128_data2: got %h want %h", out_data, {t[63:0], d[511:64]});
        end
        cyc(IDLE_BEAT, ALL_CTRL);
        chk_beat("p128_after", 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    endtask

    task automatic test_term20;
        logic [511:0] s, b;
        s = mk_start(8'h20);
        b = with_byte(mk(8'hA0), 20, 8'hFD);
        cyc(s, 64'h1);
        cyc(b, ctrl_from(20));
        chk_beat("t20_beat1", 1'b1, 1'b1, 1'b0, 6'd0, 1'b0);
        cyc(IDLE_BEAT, ALL_CTRL);
        chk_beat("t20_flush", 1'b1, 1'b0, 1'b1, 6'd52, 1'b0);
        n_cmp++;
        if (out_data[95:0] !== b[159:64]) begin
            n_bad++;
            $display("FAIL t20_flush_data: got %h want %h", out_data[95:0], b[159:64]);
        end
        cyc(IDLE_BEAT, ALL_CTRL);
        chk_beat("t20_after", 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    endtask

    task automatic test_lost_term;
        cyc(mk_start(8'h30), 64'h1);
        cyc(mk(8'h31), 64'h0);
        chk_beat("lost_beat1", 1'b1, 1'b1, 1'b0, 6'd0, 1'b0);
        cyc(IDLE_BEAT, ALL_CTRL);
        chk_beat("lost_eof", 1'b1, 1'b0, 1'b1, 6'd8, 1'b1);
        cyc(IDLE_BEAT, ALL_CTRL);
        chk_beat("lost_after", 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    endtask

    task automatic test_err_char;
        cyc(mk_start(8'h50), 64'h1);
        cyc(with_byte(mk(8'h51), 5, 8'hFE), ctrl_from(5));
        chk_beat("errc_eof", 1'b1, 1'b1, 1'b1, 6'd3, 1'b1);
        cyc(IDLE_BEAT, ALL_CTRL);
        chk_beat("errc_after", 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    endtask

    task automatic test_back_to_back;
        logic [511:0] s2, d2;
        s2 = mk_start(8'h70);
        d2 = mk(8'h90);
        cyc(mk_start(8'h60), 64'h1);
        cyc(with_byte(mk(8'h61), 40, 8'hFD), ctrl_from(40));
        chk_beat("b2b_full", 1'b1, 1'b1, 1'b0, 6'd0, 1'b0);
        cyc(s2, 64'h1);
        chk_beat("b2b_flush", 1'b1, 1'b0, 1'b1, 6'd32, 1'b0);
        cyc(d2, 64'h0);
        chk_beat("b2b_sof2", 1'b1, 1'b1, 1'b0, 6'd0, 1'b0);
        n_cmp++;
        if (out_data !== {d2[63:0], s2[511:64]}) begin
            n_bad++;
            $display("FAIL b2b_data2: got %h want %h", out_data, {d2[63:0], s2[511:64]});
        end
        cyc(with_byte(mk(8'h91), 9, 8'hFD), ctrl_from(9));
        chk_beat("t9_full", 1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
        cyc(IDLE_BEAT, ALL_CTRL);
        chk_beat("t9_flush", 1'b1, 1'b0, 1'b1, 6'd63, 1'b0);
    endtask

    task automatic test_start_abort;
        cyc(mk_start(8'hB0), 64'h1);
        cyc(mk(8'hB1), 64'h0);
        cyc(mk_start(8'hC0), 64'h1);
        chk_beat("abort_eof", 1'b1, 1'b0, 1'b1, 6'd8, 1'b1);
        cyc(mk(8'hC1), 64'h0);
        chk_beat("abort_sof", 1'b1, 1'b1, 1'b0, 6'd0, 1'b0);
        cyc(IDLE_BEAT, ALL_CTRL);
        chk_beat("abort_end", 1'b1, 1'b0, 1'b1, 6'd8, 1'b1);
    endtask

    task automatic test_runt;
        rst = 1'b1;
        cyc(IDLE_BEAT, ALL_CTRL);
        rst = 1'b0;
        cyc(with_byte(mk_start(8'hD0), 30, 8'hFD), ctrl_from(30) | 64'h1);
        chk_beat("runt_0", 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
        cyc(IDLE_BEAT, ALL_CTRL);
        chk_beat("runt_1", 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
        cyc(IDLE_BEAT, ALL_CTRL);
        chk_beat("runt_2", 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
`ifdef CGMII_RX_STATS_EN
        n_cmp++;
        if (stat_runts !== 32'd1 || stat_pkts !== 32'd0) begin
            n_bad++;
            $display("FAIL runt_stats: got runts=%0d pkts=%0d want runts=1 pkts=0", stat_runts, stat_pkts);
        end
`endif
    endtask

    task automatic test_reset_mid;
        logic [511:0] s, d;
        cyc(mk_start(8'hE0), 64'h1);
        cyc(mk(8'hE1), 64'h0);
        chk_beat("rmid_pre", 1'b1, 1'b1, 1'b0, 6'd0, 1'b0);
        rst = 1'b1;
        cyc(mk(8'hE2), 64'h0);
        rst = 1'b0;
        n_cmp++;
        if ({out_data, out_valid, out_sof, out_eof, out_empty, out_err} !== '0) begin
            n_bad++;
            $display("FAIL rmid_zero: got valid=%0b eof=%0b data_nonzero=%0b want all zero",
                     out_valid, out_eof, |out_data);
        end
        cyc(with_byte(mk(8'hE3), 3, 8'hFD), ctrl_from(3));
        chk_beat("rmid_noeof", 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
        s = mk_start(8'h01);
        d = mk(8'h02);
        cyc(s, 64'h1);
        cyc(d, 64'h0);
        chk_beat("rmid_restart", 1'b1, 1'b1, 1'b0, 6'd0, 1'b0);
        n_cmp++;
        if (out_data !== {d[63:0], s[511:64]}) begin
            n_bad++;
            $display("FAIL rmid_data: got %h want %h", out_data, {d[63:0], s[511:64]});
        end
        cyc(with_byte(mk(8'h03), 0, 8'hFD), ctrl_from(0));
        chk_beat("rmid_t0", 1'b1, 1'b0, 1'b1, 6'd8, 1'b0);
    endtask

    initial begin
        test_reset;
        test_pkt128;
        test_term20;
        test_lost_term;
        test_err_char;
        test_back_to_back;
        test_start_abort;
        test_runt;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
